// File: rtl/apb_requester.sv
// APB requester: turns a local valid/ready command into an APB SETUP/ACCESS transfer with a one-cycle response pulse.
// Optional ACCESS wait-state timeout is enabled by defining APB_REQ_TIMEOUT_EN.
module apb_requester #(
   parameter int DataWidth     = 32,
   parameter int AddrWidth     = 32,
   parameter int TimeoutCycles = 16
) (
   input  logic                   PCLK,
   input  logic                   reset,
   input  logic                   CmdValid,
   input  logic                   CmdWrite,
   input  logic [AddrWidth-1:0]   CmdAddr,
   input  logic [DataWidth-1:0]   CmdWData,
   input  logic [DataWidth/8-1:0] CmdStrb,
   output logic                   CmdReady,
   output logic                   RspValid,
   output logic [DataWidth-1:0]   RspRData,
   output logic                   RspTimeout,
   output logic                   PSEL,
   output logic                   PENABLE,
   output logic                   PWRITE,
   output logic [AddrWidth-1:0]   PADDR,
   output logic [DataWidth-1:0]   PWDATA,
   output logic [DataWidth/8-1:0] PSTRB,
   input  logic                   PREADY,
   input  logic [DataWidth-1:0]   PRDATA
);

   localparam int StrbWidth = DataWidth / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t state_r;
   logic   accept_s;
   logic   complete_s;
   logic   timeout_s;

   // Command handshake and transfer-end qualifiers derived from the current state
   always_comb begin
      CmdReady   = 1'b0;
      complete_s = 1'b0;
      case (state_r)
         IDLE: begin
            CmdReady   = 1'b1;
            complete_s = 1'b0;
         end
         SETUP: begin
            CmdReady   = 1'b0;
            complete_s = 1'b0;
         end
         ACCESS: begin
            CmdReady   = PREADY;
            complete_s = PREADY;
         end
         default: begin
            CmdReady   = 1'b0;
            complete_s = 1'b0;
         end
      endcase
      if (CmdValid && CmdReady) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

`ifdef APB_REQ_TIMEOUT_EN
   localparam int CntWidth = $clog2(TimeoutCycles) + 1;
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

   logic [CntWidth-1:0] wait_cnt_r;
   logic                rsp_timeout_r;

   // Abort condition: last permitted wait cycle and the completer is still not ready
   always_comb begin
      if ((state_r == ACCESS) && !PREADY && (wait_cnt_r == CntLast)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Wait-state counter, cleared on the way into ACCESS and saturating rather than wrapping
   always_ff @(posedge PCLK or posedge reset) begin
      if (reset) begin
         wait_cnt_r    <= {CntWidth{1'b0}};
         rsp_timeout_r <= 1'b0;
      end else begin
         rsp_timeout_r <= timeout_s;
         if (state_r == SETUP) begin
            wait_cnt_r <= {CntWidth{1'b0}};
         end else if ((state_r == ACCESS) && !PREADY && (wait_cnt_r != {CntWidth{1'b1}})) begin
            wait_cnt_r <= wait_cnt_r + CntWidth'(1);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end

   assign RspTimeout = rsp_timeout_r;
`else
   assign timeout_s  = 1'b0;
   assign RspTimeout = 1'b0;
`endif

   // Transfer FSM with registered APB controls, payload and response
   always_ff @(posedge PCLK or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         PSEL     <= 1'b0;
         PENABLE  <= 1'b0;
         PWRITE   <= 1'b0;
         PADDR    <= {AddrWidth{1'b0}};
         PWDATA   <= {DataWidth{1'b0}};
         PSTRB    <= {StrbWidth{1'b0}};
         RspValid <= 1'b0;
         RspRData <= {DataWidth{1'b0}};
      end else begin
         RspValid <= complete_s;
         // PWRITE still describes the finishing transfer here; the new command lands after this edge
         if (complete_s && !PWRITE) begin
            RspRData <= PRDATA;
         end else begin
            RspRData <= RspRData;
         end

         if (accept_s) begin
            state_r <= SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= CmdWrite;
            PADDR   <= CmdAddr;
            PWDATA  <= CmdWData;
            PSTRB   <= CmdWrite ? CmdStrb : {StrbWidth{1'b0}};
         end else begin
            case (state_r)
               IDLE: begin
                  state_r <= IDLE;
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
               end
               SETUP: begin
                  state_r <= ACCESS;
                  PSEL    <= 1'b1;
                  PENABLE <= 1'b1;
               end
               ACCESS: begin
                  if (complete_s || timeout_s) begin
                     state_r <= IDLE;
                     PSEL    <= 1'b0;
                     PENABLE <= 1'b0;
                  end else begin
                     state_r <= ACCESS;
                     PSEL    <= 1'b1;
                     PENABLE <= 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level model (cycles since acceptance, wait count).
module tb_apb_requester;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 4;

   logic          PCLK = 1'b0;
   logic          reset;
   logic          CmdValid, CmdWrite, CmdReady;
   logic [AW-1:0] CmdAddr;
   logic [DW-1:0] CmdWData;
   logic [SW-1:0] CmdStrb;
   logic          RspValid, RspTimeout;
   logic [DW-1:0] RspRData;
   logic          PSEL, PENABLE, PWRITE, PREADY;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;
   logic [SW-1:0] PSTRB;

   int errors = 0;
   int checks = 0;

   always #5 PCLK = ~PCLK;

   apb_requester #(.DataWidth(DW), .AddrWidth(AW), .TimeoutCycles(TO)) dut (
      .PCLK(PCLK), .reset(reset),
      .CmdValid(CmdValid), .CmdWrite(CmdWrite), .CmdAddr(CmdAddr), .CmdWData(CmdWData),
      .CmdStrb(CmdStrb), .CmdReady(CmdReady),
      .RspValid(RspValid), .RspRData(RspRData), .RspTimeout(RspTimeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
   );

   // Model: a transfer is "active" from acceptance; age 1 is its setup cycle, age >= 2 its access cycles
   logic          m_act;
   int            m_age, m_waits;
   logic          m_write, m_rv, m_to;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rd;
   logic [SW-1:0] m_strb;
   logic          in_access_m, rdy_m, done_m, tmo_m;

   always_comb begin
      in_access_m = m_act && (m_age >= 2);
      rdy_m       = !m_act || (in_access_m && PREADY);
      done_m      = in_access_m && PREADY;
`ifdef APB_REQ_TIMEOUT_EN
      tmo_m       = in_access_m && !PREADY && (m_waits == TO - 1);
`else
      tmo_m       = 1'b0;
`endif
   end

   always @(posedge PCLK or posedge reset) begin
      if (reset) begin
         m_act <= 1'b0; m_age <= 0; m_waits <= 0;
         m_write <= 1'b0; m_addr <= '0; m_wdata <= '0; m_strb <= '0;
         m_rv <= 1'b0; m_to <= 1'b0; m_rd <= '0;
      end else begin
         m_rv <= done_m;
         m_to <= tmo_m;
         if (done_m && !m_write) m_rd <= PRDATA;
         if (CmdValid && rdy_m) begin
            m_act <= 1'b1; m_age <= 1; m_waits <= 0;
            m_write <= CmdWrite; m_addr <= CmdAddr; m_wdata <= CmdWData;
            m_strb <= CmdWrite ? CmdStrb : '0;
         end else if (done_m || tmo_m) begin
            m_act <= 1'b0;
         end else if (m_act) begin
            m_age <= m_age + 1;
            if (in_access_m) m_waits <= m_waits + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, mid-cycle
   initial begin
      forever begin
         @(negedge PCLK);
         chk("cmdready", 64'(CmdReady), 64'(rdy_m));
         chk("psel",     64'(PSEL),     64'(m_act));
         chk("penable",  64'(PENABLE),  64'(in_access_m));
         chk("pwrite",   64'(PWRITE),   64'(m_write));
         chk("paddr",    64'(PADDR),    64'(m_addr));
         chk("pwdata",   64'(PWDATA),   64'(m_wdata));
         chk("pstrb",    64'(PSTRB),    64'(m_strb));
         chk("rspvalid", 64'(RspValid), 64'(m_rv));
         chk("rsprdata", 64'(RspRData), 64'(m_rd));
         chk("rsptmo",   64'(RspTimeout), 64'(m_to));
      end
   end

   task automatic at_mid;
      @(negedge PCLK);
      #1;
   endtask

   task automatic next_edge;
      @(posedge PCLK);
      #1;
   endtask

   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      CmdValid = 1'b1; CmdWrite = w; CmdAddr = a; CmdWData = d; CmdStrb = s;
   endtask

   initial begin
      int pen;
      logic seen;
      logic [6:0] psel_v, rv_v;
      logic held;

      reset = 1'b1; CmdValid = 1'b0; CmdWrite = 1'b0; CmdAddr = '0; CmdWData = '0;
      CmdStrb = '0; PREADY = 1'b0; PRDATA = '0;
      repeat (2) @(posedge PCLK);
      #1 reset = 1'b0;
      at_mid;
      chk("rst_cmdready", 64'(CmdReady), 64'd1);
      chk("rst_psel", 64'(PSEL), 64'd0);
      chk("rst_rdata", 64'(RspRData), 64'd0);

      // Write, zero wait
      send(1'b1, 32'h10, 32'hA5A5_0F0F, 4'b0011); PREADY = 1'b1;
      next_edge; CmdValid = 1'b0;
      at_mid;
      chk("w_setup_psel", 64'(PSEL), 64'd1);
      chk("w_setup_pen", 64'(PENABLE), 64'd0);
      chk("w_setup_rdy", 64'(CmdReady), 64'd0);
      chk("w_pstrb", 64'(PSTRB), 64'h3);
      chk("w_paddr", 64'(PADDR), 64'h10);
      next_edge; at_mid;
      chk("w_access_pen", 64'(PENABLE), 64'd1);
      chk("w_access_rv", 64'(RspValid), 64'd0);
      next_edge; at_mid;
      chk("w_rspvalid", 64'(RspValid), 64'd1);
      chk("w_done_psel", 64'(PSEL), 64'd0);
      next_edge; at_mid;
      chk("w_rv_pulse", 64'(RspValid), 64'd0);

      // Read with three wait states
      send(1'b0, 32'h20, 32'h1234_5678, 4'hF); PREADY = 1'b0;
      next_edge; CmdValid = 1'b0;
      at_mid;
      chk("r_pstrb_zero", 64'(PSTRB), 64'd0);
      pen = 0;
      for (int i = 0; i < 4; i++) begin
         next_edge;
         if (i == 3) begin PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF; end
         at_mid;
         if (PENABLE) pen++;
      end
      next_edge; at_mid;
      chk("r_penable_cycles", 64'(pen), 64'd4);
      chk("r_rspvalid", 64'(RspValid), 64'd1);
      chk("r_rdata", 64'(RspRData), 64'hDEAD_BEEF);
      PRDATA = 32'h0BAD_F00D;

      // Back-to-back writes at zero wait
      send(1'b1, 32'h30, 32'h0000_0001, 4'hF); PREADY = 1'b1;
      for (int i = 0; i < 7; i++) begin
         next_edge;
         if (i == 4) CmdValid = 1'b0;
         at_mid;
         psel_v[6-i] = PSEL;
         rv_v[6-i]   = RspValid;
      end
      chk("b2b_psel", 64'(psel_v), 64'b1111110);
      chk("b2b_rspvalid", 64'(rv_v), 64'b0010101);
      chk("b2b_rdata_held", 64'(RspRData), 64'hDEAD_BEEF);

      // Reset during the second wait cycle of a read
      send(1'b0, 32'h44, 32'h0, 4'h0); PREADY = 1'b0;
      next_edge; CmdValid = 1'b0;
      next_edge;
      next_edge;
      reset = 1'b1;
      #1;
      chk("ra_psel", 64'(PSEL), 64'd0);
      chk("ra_penable", 64'(PENABLE), 64'd0);
      chk("ra_paddr", 64'(PADDR), 64'd0);
      chk("ra_rspvalid", 64'(RspValid), 64'd0);
      chk("ra_rdata", 64'(RspRData), 64'd0);
      next_edge; PREADY = 1'b1; reset = 1'b0;
      at_mid;
      chk("ra_cmdready", 64'(CmdReady), 64'd1);
      next_edge; at_mid;
      chk("ra_no_rsp", 64'(RspValid), 64'd0);

      // Completer never ready
      send(1'b0, 32'h50, 32'h0, 4'h0); PREADY = 1'b0;
      next_edge; CmdValid = 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
      pen = 0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!seen) begin
            next_edge; at_mid;
            if (RspTimeout) begin
               seen = 1'b1;
               chk("to_psel", 64'(PSEL), 64'd0);
               chk("to_rspvalid", 64'(RspValid), 64'd0);
            end else if (PENABLE) begin
               pen++;
            end
         end
      end
      chk("to_seen", 64'(seen), 64'd1);
      chk("to_access_cycles", 64'(pen), 64'd4);
      next_edge; at_mid;
      chk("to_pulse", 64'(RspTimeout), 64'd0);
`else
      held = 1'b1;
      for (int i = 0; i < 100; i++) begin
         next_edge; at_mid;
         if (!PSEL || RspTimeout) held = 1'b0;
      end
      chk("noto_psel_held", 64'(held), 64'd1);
      PREADY = 1'b1;
      next_edge; next_edge; at_mid;
      chk("noto_psel_drop", 64'(PSEL), 64'd0);
`endif

      // Randomized traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         next_edge;
         CmdValid = 1'($urandom_range(0, 1));
         CmdWrite = 1'($urandom_range(0, 1));
         CmdAddr  = $urandom;
         CmdWData = $urandom;
         CmdStrb  = 4'($urandom_range(0, 15));
         PREADY   = ($urandom_range(0, 9) < 6);
         PRDATA   = $urandom;
         if ($urandom_range(0, 399) == 0) begin
            reset = 1'b1;
            #2 reset = 1'b0;
         end
      end
      CmdValid = 1'b0; PREADY = 1'b1;
      repeat (4) next_edge;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
